// File: rtl/dds_hop_sched.sv
// Frequency-hop scheduler for the CORDIC DDS: walks a host-written table of
// {phase increment, dwell} entries, restarting the DDS at a common phase on every hop.
module dds_hop_sched #(
  parameter int PW    = 14,
  parameter int DW    = 16,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          I_clk,
  input  logic          I_rst,
  input  logic          I_wr_en,
  input  logic [AW-1:0] I_wr_addr,
  input  logic [PW-1:0] I_wr_inc,
  input  logic [DW-1:0] I_wr_dwell,
  input  logic          I_start,
  input  logic          I_abort,
  input  logic [AW:0]   I_num_hops,
  input  logic          I_loop,
  input  logic [PW-1:0] I_start_phase,
  output logic [PW-1:0] O_init_phase,
  output logic [PW-1:0] O_inc_phase,
  output logic          O_change_phase,
  output logic [AW-1:0] O_hop_idx,
  output logic          O_busy,
  output logic          O_done,
  output logic          O_err
);

  typedef struct packed {
    logic [PW-1:0] inc;
    logic [DW-1:0] dwell;
  } hop_ent_t;

  typedef enum logic [1:0] {S_IDLE, S_HOP, S_DWELL} state_t;

  hop_ent_t      tbl [DEPTH];
  state_t        state, state_nx;
  logic [AW-1:0] k_r, k_nx;
  logic [DW-1:0] cnt_r, cnt_nx, cnt_ld;
  logic [AW:0]   num_r;
  logic          loop_r;
  logic [PW-1:0] phase_r, phase_nx;

  logic     busy, wr_ok, num_ok, start_ok, start_bad, last_hop;
  logic     hop_go, done_nx, err_nx;
  hop_ent_t ent;

  assign busy      = (state != S_IDLE);
  assign wr_ok     = I_wr_en && !busy;
  assign num_ok    = (I_num_hops != '0) && (I_num_hops <= (AW+1)'(DEPTH));
  assign start_ok  = (state == S_IDLE) && I_start && !I_abort && num_ok;
  assign start_bad = (state == S_IDLE) && I_start && !I_abort && !num_ok;
  assign last_hop  = ({1'b0, k_r} == (num_r - 1'b1));
  assign O_busy    = busy;

  // Hop table: writes land only while idle.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
    end else if (wr_ok) begin
      tbl[I_wr_addr].inc   <= I_wr_inc;
      tbl[I_wr_addr].dwell <= I_wr_dwell;
    end
  end

  // State register.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state   <= S_IDLE;
      k_r     <= '0;
      cnt_r   <= '0;
      num_r   <= '0;
      loop_r  <= 1'b0;
      phase_r <= '0;
    end else begin
      state <= state_nx;
      k_r   <= k_nx;
      cnt_r <= hop_go ? cnt_ld : cnt_nx;
      if (start_ok) begin
        num_r   <= I_num_hops;
        loop_r  <= I_loop;
        phase_r <= I_start_phase;
      end
    end
  end

  // Next state: a hop ends when its remaining-cycle count reaches zero.
  always_comb begin
    state_nx = state;
    k_nx     = k_r;
    cnt_nx   = cnt_r;
    unique case (state)
      S_IDLE: begin
        if (start_ok) begin
          state_nx = S_HOP;
          k_nx     = '0;
        end
      end
      S_HOP, S_DWELL: begin
        if (I_abort) begin
          state_nx = S_IDLE;
        end else if (cnt_r == '0) begin
          if (last_hop && !loop_r) begin
            state_nx = S_IDLE;
          end else begin
            state_nx = S_HOP;
            k_nx     = last_hop ? '0 : k_r + 1'b1;
          end
        end else begin
          state_nx = S_DWELL;
          cnt_nx   = cnt_r - 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Output decode. A write accepted alongside a start is forwarded so the
  // first hop of that run already sees it.
  always_comb begin
    hop_go = (state_nx == S_HOP);
    ent    = tbl[k_nx];
    if (wr_ok && (I_wr_addr == k_nx)) begin
      ent.inc   = I_wr_inc;
      ent.dwell = I_wr_dwell;
    end
    cnt_ld   = (ent.dwell == '0) ? '0 : ent.dwell - 1'b1;
    done_nx  = busy && (state_nx == S_IDLE) && !I_abort;
    err_nx   = start_bad || (I_wr_en && busy);
    phase_nx = start_ok ? I_start_phase : phase_r;
  end

  // DDS-facing registers; tone settings hold after the run ends.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      O_init_phase   <= '0;
      O_inc_phase    <= '0;
      O_change_phase <= 1'b0;
      O_hop_idx      <= '0;
      O_done         <= 1'b0;
      O_err          <= 1'b0;
    end else begin
      O_change_phase <= hop_go;
      O_done         <= done_nx;
      O_err          <= err_nx;
      if (hop_go) begin
        O_inc_phase  <= ent.inc;
        O_init_phase <= phase_nx;
        O_hop_idx    <= k_nx;
      end
    end
  end

endmodule

// File: tb/tb_dds_hop_sched.sv
// Bench for dds_hop_sched: start-legality vector table, hand sequences for
// busy writes and mid-run reset, and random runs against a hop-schedule model.
module tb_dds_hop_sched;
  localparam int PW = 14, DW = 16, DEPTH = 8, AW = 3;

  logic          clk = 1'b0;
  logic          I_rst, I_wr_en, I_start, I_abort, I_loop;
  logic [AW-1:0] I_wr_addr;
  logic [PW-1:0] I_wr_inc, I_start_phase;
  logic [DW-1:0] I_wr_dwell;
  logic [AW:0]   I_num_hops;
  logic [PW-1:0] O_init_phase, O_inc_phase;
  logic          O_change_phase, O_busy, O_done, O_err;
  logic [AW-1:0] O_hop_idx;

  dds_hop_sched #(.PW(PW), .DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .I_clk(clk), .I_rst(I_rst), .I_wr_en(I_wr_en), .I_wr_addr(I_wr_addr),
    .I_wr_inc(I_wr_inc), .I_wr_dwell(I_wr_dwell), .I_start(I_start), .I_abort(I_abort),
    .I_num_hops(I_num_hops), .I_loop(I_loop), .I_start_phase(I_start_phase),
    .O_init_phase(O_init_phase), .O_inc_phase(O_inc_phase), .O_change_phase(O_change_phase),
    .O_hop_idx(O_hop_idx), .O_busy(O_busy), .O_done(O_done), .O_err(O_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  logic [PW-1:0] m_inc   [DEPTH];
  logic [DW-1:0] m_dwell [DEPTH];
  logic [PW-1:0] cur_inc, cur_init;
  logic [AW-1:0] cur_idx;

  typedef struct {
    logic        start, abort;
    logic [AW:0] num;
    logic        e_busy, e_err, e_chg;
  } vec_t;
  vec_t vt [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_init"}, O_init_phase, 0);
    chk({tag, "_inc"},  O_inc_phase, 0);
    chk({tag, "_chg"},  O_change_phase, 0);
    chk({tag, "_idx"},  O_hop_idx, 0);
    chk({tag, "_busy"}, O_busy, 0);
    chk({tag, "_done"}, O_done, 0);
    chk({tag, "_err"},  O_err, 0);
  endtask

  task automatic wr_entry(input logic [AW-1:0] a, input logic [PW-1:0] inc, input logic [DW-1:0] dw);
    I_wr_en = 1'b1; I_wr_addr = a; I_wr_inc = inc; I_wr_dwell = dw;
    step();
    I_wr_en = 1'b0;
    m_inc[a] = inc; m_dwell[a] = dw;
    chk("wr_err", O_err, 0);
  endtask

  // Expected behaviour from the hop schedule: hop k at T(k), T(k+1) = T(k) + max(dwell,1),
  // times counted in cycles after the start cycle. a < 0 means no abort.
  task automatic run_check(input logic [AW:0] num, input logic lp, input logic [PW-1:0] ph,
                           input int a, input logic wr, input logic [AW-1:0] wa,
                           input logic [PW-1:0] wi, input logic [DW-1:0] wd);
    int inf = 1 << 30;
    int a_eff = (a < 0) ? inf : a;
    int nt = 1, mk = 0, done_t = inf;
    bit active = 1'b1;
    I_num_hops = num; I_loop = lp; I_start_phase = ph; I_start = 1'b1;
    if (wr) begin
      I_wr_en = 1'b1; I_wr_addr = wa; I_wr_inc = wi; I_wr_dwell = wd;
      m_inc[wa] = wi; m_dwell[wa] = wd;
    end
    step();
    I_start = 1'b0; I_wr_en = 1'b0;
    for (int rel = 1; rel < 2000; rel++) begin
      bit pulse;
      pulse = active && (rel == nt) && (rel <= a_eff);
      if (pulse) begin
        cur_inc  = m_inc[mk];
        cur_init = ph;
        cur_idx  = mk[AW-1:0];
        nt += (m_dwell[mk] == '0) ? 1 : int'(m_dwell[mk]);
        mk++;
        if (mk == int'(num)) begin
          mk = 0;
          if (!lp) begin active = 1'b0; done_t = nt; end
        end
      end
      chk("run_chg",  O_change_phase, pulse);
      chk("run_idx",  O_hop_idx, cur_idx);
      chk("run_inc",  O_inc_phase, cur_inc);
      chk("run_init", O_init_phase, cur_init);
      chk("run_busy", O_busy, (rel <= a_eff) && (lp || rel < done_t));
      chk("run_done", O_done, (rel == done_t) && (done_t <= a_eff));
      chk("run_err",  O_err, 0);
      I_abort = (rel == a_eff);
      if (rel >= a_eff + 2 || (done_t != inf && rel >= done_t + 1)) break;
      step();
    end
    I_abort = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [PW-1:0] ph_m = 14'h3800;  // -2048
    I_rst = 1'b1; I_wr_en = 1'b0; I_start = 1'b0; I_abort = 1'b0; I_loop = 1'b0;
    I_wr_addr = '0; I_wr_inc = '0; I_wr_dwell = '0; I_num_hops = '0; I_start_phase = '0;
    for (int i = 0; i < DEPTH; i++) begin m_inc[i] = '0; m_dwell[i] = '0; end
    cur_inc = '0; cur_init = '0; cur_idx = '0;
    repeat (3) step();
    chk_zero("reset");
    I_rst = 1'b0;
    step();

    // Cleared table read-back.
    run_check(4'd1, 1'b0, 14'h1234, -1, 1'b0, '0, '0, '0);

    // Start legality in IDLE.
    vt[0] = '{1'b1, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0};
    vt[1] = '{1'b1, 1'b0, 4'd9,  1'b0, 1'b1, 1'b0};
    vt[2] = '{1'b1, 1'b0, 4'd15, 1'b0, 1'b1, 1'b0};
    vt[3] = '{1'b1, 1'b0, 4'd1,  1'b1, 1'b0, 1'b1};
    vt[4] = '{1'b1, 1'b0, 4'd8,  1'b1, 1'b0, 1'b1};
    vt[5] = '{1'b1, 1'b1, 4'd3,  1'b0, 1'b0, 1'b0};
    vt[6] = '{1'b0, 1'b1, 4'd3,  1'b0, 1'b0, 1'b0};
    vt[7] = '{1'b0, 1'b0, 4'd3,  1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      I_start = vt[i].start; I_abort = vt[i].abort; I_num_hops = vt[i].num;
      I_loop = 1'b0; I_start_phase = 14'h00AB;
      step();
      I_start = 1'b0; I_abort = 1'b0;
      chk("vec_busy", O_busy, vt[i].e_busy);
      chk("vec_err",  O_err, vt[i].e_err);
      chk("vec_chg",  O_change_phase, vt[i].e_chg);
      if (vt[i].e_busy) begin
        cur_inc = m_inc[0]; cur_init = 14'h00AB; cur_idx = '0;
        chk("vec_inc", O_inc_phase, cur_inc);
        I_abort = 1'b1;
        step();
        I_abort = 1'b0;
        chk("vec_abort_busy", O_busy, 0);
        chk("vec_abort_done", O_done, 0);
      end
      step();
      chk("vec_idle_chg", O_change_phase, 0);
    end

    // Three-hop table, single pass then looped with abort.
    wr_entry(3'd0, 14'd100, 16'd4);
    wr_entry(3'd1, 14'd200, 16'd2);
    wr_entry(3'd2, 14'd300, 16'd0);
    run_check(4'd3, 1'b0, ph_m, -1, 1'b0, '0, '0, '0);
    run_check(4'd3, 1'b1, ph_m, 10, 1'b0, '0, '0, '0);
    chk("loop_abort_inc", O_inc_phase, 14'd100);

    // Write while busy is dropped and flagged.
    wr_entry(3'd0, 14'd50, 16'd5);
    I_num_hops = 4'd1; I_loop = 1'b0; I_start_phase = 14'h1111; I_start = 1'b1;
    step();
    I_start = 1'b0;
    chk("wb_chg", O_change_phase, 1);
    chk("wb_inc", O_inc_phase, 14'd50);
    I_wr_en = 1'b1; I_wr_addr = 3'd0; I_wr_inc = 14'd999; I_wr_dwell = 16'd0;
    step();
    I_wr_en = 1'b0;
    chk("wb_err", O_err, 1);
    chk("wb_busy", O_busy, 1);
    repeat (3) step();
    chk("wb_busy_late", O_busy, 1);
    chk("wb_done_early", O_done, 0);
    step();
    chk("wb_done", O_done, 1);
    chk("wb_busy_end", O_busy, 0);
    cur_inc = 14'd50; cur_init = 14'h1111; cur_idx = '0;
    run_check(4'd1, 1'b0, 14'h2222, -1, 1'b0, '0, '0, '0);
    run_check(4'd1, 1'b0, 14'h3333, -1, 1'b1, 3'd0, 14'd777, 16'd2);

    // Reset during the dwell of hop 1.
    wr_entry(3'd0, 14'd100, 16'd4);
    I_num_hops = 4'd3; I_loop = 1'b0; I_start_phase = ph_m; I_start = 1'b1;
    step();
    I_start = 1'b0;
    repeat (4) step();
    chk("rst_hop1_chg", O_change_phase, 1);
    chk("rst_hop1_idx", O_hop_idx, 1);
    chk("rst_hop1_inc", O_inc_phase, 14'd200);
    step();
    chk("rst_dwell_chg", O_change_phase, 0);
    chk("rst_dwell_busy", O_busy, 1);
    I_rst = 1'b1;
    step();
    I_rst = 1'b0;
    chk_zero("midrst");
    for (int i = 0; i < DEPTH; i++) begin m_inc[i] = '0; m_dwell[i] = '0; end
    cur_inc = '0; cur_init = '0; cur_idx = '0;
    step();
    chk("midrst_chg", O_change_phase, 0);
    run_check(4'd2, 1'b0, 14'h0FFF, -1, 1'b0, '0, '0, '0);

    // Random runs.
    for (int it = 0; it < 25; it++) begin
      int nw, a;
      logic [AW:0] num;
      logic lp, wr;
      nw = int'($urandom_range(0, 3));
      for (int w = 0; w < nw; w++)
        wr_entry(AW'($urandom_range(0, DEPTH-1)), PW'($urandom), DW'($urandom_range(0, 5)));
      num = (AW+1)'($urandom_range(1, DEPTH));
      lp  = 1'($urandom_range(0, 1));
      wr  = 1'($urandom_range(0, 1));
      if (lp) a = int'($urandom_range(1, 30));
      else    a = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 20)) : -1;
      run_check(num, lp, PW'($urandom), a, wr, AW'($urandom_range(0, DEPTH-1)),
                PW'($urandom), DW'($urandom_range(0, 5)));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
